// File: rtl/risc8_io_pkg.sv
// Shared risc8 IO-bus definitions: bus widths and GPIO register offsets.
package risc8_io_pkg;
  localparam int IO_ADDR_W = 7;
  localparam int DATA_W    = 8;

  typedef logic [IO_ADDR_W-1:0] io_addr_t;
  typedef logic [DATA_W-1:0]    io_data_t;

  localparam io_addr_t OFS_PIN   = 7'd0;
  localparam io_addr_t OFS_DDR   = 7'd1;
  localparam io_addr_t OFS_PORT  = 7'd2;
  localparam io_addr_t OFS_PCMSK = 7'd3;
  localparam io_addr_t OFS_PCIF  = 7'd4;
endpackage

// File: rtl/risc8_sync2.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module risc8_sync2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] meta_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end
endmodule

// File: rtl/risc8_gpio_port.sv
// AVR-style PIN/DDR/PORT GPIO port on the risc8 IO bus, 1-cycle registered reads.
// Optional pin-change interrupt (PCMSK/PCIF) enabled by defining RISC8_GPIO_PCINT_EN.
module risc8_gpio_port
  import risc8_io_pkg::*;
#(
  parameter io_addr_t BASE = 7'h36
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IO_ADDR_W-1:0] addr,
  input  logic                 ren,
  input  logic                 wen,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata,
  output logic                 valid,
  output logic [DATA_W-1:0]    port,
  input  logic [DATA_W-1:0]    pin,
  output logic [DATA_W-1:0]    ddr,
  output logic                 irq
);
  io_addr_t ofs_p0;
  io_data_t sync_pin;
  io_data_t rd_data_p0;
  logic     rd_hit_p0;
  logic     wr_pin_p0, wr_ddr_p0, wr_port_p0;

  risc8_sync2 #(.DATA_W(DATA_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin),
    .q     (sync_pin)
  );

  // Addresses below BASE wrap to large offsets and so never decode.
  assign ofs_p0     = addr - BASE;
  assign wr_pin_p0  = wen && (ofs_p0 == OFS_PIN);
  assign wr_ddr_p0  = wen && (ofs_p0 == OFS_DDR);
  assign wr_port_p0 = wen && (ofs_p0 == OFS_PORT);

`ifdef RISC8_GPIO_PCINT_EN
  io_data_t pcmsk;
  io_data_t prev_pin;
  logic     pcif;
  logic     pc_event;

  assign pc_event = |((sync_pin ^ prev_pin) & pcmsk);
  assign irq      = pcif;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcmsk    <= '0;
      prev_pin <= '0;
      pcif     <= 1'b0;
    end else begin
      prev_pin <= sync_pin;
      if (wen && (ofs_p0 == OFS_PCMSK)) pcmsk <= wdata;
      // A detected change in the same cycle overrides a software clear.
      if (pc_event) pcif <= 1'b1;
      else if (wen && (ofs_p0 == OFS_PCIF) && wdata[0]) pcif <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data_p0 = '0;
    rd_hit_p0  = 1'b1;
    case (ofs_p0)
      OFS_PIN:   rd_data_p0 = sync_pin;
      OFS_DDR:   rd_data_p0 = ddr;
      OFS_PORT:  rd_data_p0 = port;
`ifdef RISC8_GPIO_PCINT_EN
      OFS_PCMSK: rd_data_p0 = pcmsk;
      OFS_PCIF:  rd_data_p0 = {{(DATA_W-1){1'b0}}, pcif};
`endif
      default:   rd_hit_p0  = 1'b0;
    endcase
  end

  // Response stage: rdata/valid carry the pre-edge register value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      rdata <= '0;
      port  <= '0;
      ddr   <= '0;
    end else begin
      valid <= ren && rd_hit_p0;
      rdata <= (ren && rd_hit_p0) ? rd_data_p0 : '0;
      if (wr_pin_p0)       port <= port ^ wdata;
      else if (wr_port_p0) port <= wdata;
      if (wr_ddr_p0)       ddr  <= wdata;
    end
  end
endmodule

// File: tb/tb_risc8_gpio_port.sv
// Self-checking bench for risc8_gpio_port: directed vector table, corner sequences,
// and randomized traffic against a history-based reference model.
module tb_risc8_gpio_port;
  localparam logic [6:0] BASE = 7'h36;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] addr;
  logic       ren, wen;
  logic [7:0] wdata, rdata, port, pin, ddr;
  logic       valid, irq;

  int vectors = 0;
  int miscompares = 0;

  risc8_gpio_port #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata),
    .rdata(rdata), .valid(valid), .port(port), .pin(pin), .ddr(ddr), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference state: register contents plus the pin values seen at the last three edges.
  logic [7:0] m_port, m_ddr, m_pcmsk;
  logic       m_pcif;
  logic [7:0] pin_hist [3];

  task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {valid,rdata,port,ddr,irq}=%h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_port = 0; m_ddr = 0; m_pcmsk = 0; m_pcif = 0;
    for (int i = 0; i < 3; i++) pin_hist[i] = 0;
  endtask

  task automatic cyc(input logic r, input logic w, input logic [6:0] a,
                     input logic [7:0] d, input logic [7:0] p);
    logic [6:0] off;
    logic [7:0] rd, sync_now, sync_old;
    logic       hit, ev;
    logic [25:0] exp;
    ren = r; wen = w; addr = a; wdata = d; pin = p;
    off = a - BASE;
    sync_now = pin_hist[1];
    sync_old = pin_hist[2];
    hit = 1'b1; rd = 8'h00;
    case (off)
      7'd0: rd = sync_now;
      7'd1: rd = m_ddr;
      7'd2: rd = m_port;
`ifdef RISC8_GPIO_PCINT_EN
      7'd3: rd = m_pcmsk;
      7'd4: rd = {7'b0, m_pcif};
`endif
      default: hit = 1'b0;
    endcase
    ev = ((sync_now ^ sync_old) & m_pcmsk) != 0;
    if (w) begin
      case (off)
        7'd0: m_port = m_port ^ d;
        7'd1: m_ddr = d;
        7'd2: m_port = d;
`ifdef RISC8_GPIO_PCINT_EN
        7'd3: m_pcmsk = d;
        7'd4: if (d[0]) m_pcif = 1'b0;
`endif
        default: ;
      endcase
    end
`ifdef RISC8_GPIO_PCINT_EN
    if (ev) m_pcif = 1'b1;
`endif
    pin_hist[2] = pin_hist[1];
    pin_hist[1] = pin_hist[0];
    pin_hist[0] = p;
    exp = {r && hit, (r && hit) ? rd : 8'h00, m_port, m_ddr, m_pcif};
    @(posedge clk); #1;
    check("model", {valid, rdata, port, ddr, irq}, exp);
    ren = 0; wen = 0;
  endtask

  typedef struct {
    logic       r, w;
    logic [6:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] er, ep, ed;
  } vec_t;

  vec_t tbl [17];
  logic [6:0] addr_pool [9];

  initial begin
    logic pcint_on;
`ifdef RISC8_GPIO_PCINT_EN
    pcint_on = 1'b1;
`else
    pcint_on = 1'b0;
`endif
    tbl[0]  = '{1, 0, 7'h37, 8'h00, 1, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1, 0, 7'h38, 8'h00, 1, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{0, 1, 7'h37, 8'hF0, 0, 8'h00, 8'h00, 8'hF0};
    tbl[3]  = '{0, 1, 7'h38, 8'hA5, 0, 8'h00, 8'hA5, 8'hF0};
    tbl[4]  = '{1, 0, 7'h37, 8'h00, 1, 8'hF0, 8'hA5, 8'hF0};
    tbl[5]  = '{1, 0, 7'h38, 8'h00, 1, 8'hA5, 8'hA5, 8'hF0};
    tbl[6]  = '{0, 1, 7'h36, 8'h0F, 0, 8'h00, 8'hAA, 8'hF0};
    tbl[7]  = '{1, 0, 7'h38, 8'h00, 1, 8'hAA, 8'hAA, 8'hF0};
    tbl[8]  = '{1, 1, 7'h38, 8'h11, 1, 8'hAA, 8'h11, 8'hF0};
    tbl[9]  = '{1, 0, 7'h35, 8'h00, 0, 8'h00, 8'h11, 8'hF0};
    tbl[10] = '{1, 0, 7'h39, 8'h00, pcint_on, 8'h00, 8'h11, 8'hF0};
    tbl[11] = '{1, 0, 7'h3A, 8'h00, pcint_on, 8'h00, 8'h11, 8'hF0};
    tbl[12] = '{1, 1, 7'h37, 8'h22, 1, 8'hF0, 8'h11, 8'h22};
    tbl[13] = '{1, 1, 7'h38, 8'h33, 1, 8'h11, 8'h33, 8'h22};
    tbl[14] = '{0, 0, 7'h38, 8'h00, 0, 8'h00, 8'h33, 8'h22};
    tbl[15] = '{0, 1, 7'h7F, 8'h55, 0, 8'h00, 8'h33, 8'h22};
    tbl[16] = '{1, 0, 7'h36, 8'h00, 1, 8'h00, 8'h33, 8'h22};
    for (int i = 0; i < 9; i++) addr_pool[i] = BASE - 7'd1 + 7'(i);
    addr_pool[8] = 7'h7F;

    reset = 1'b0; ren = 0; wen = 0; addr = 0; wdata = 0; pin = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", {valid, rdata, port, ddr, irq}, 26'd0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 8'h00);
      check($sformatf("table[%0d]", i), {valid, rdata, port, ddr, irq},
            {tbl[i].ev, tbl[i].er, tbl[i].ep, tbl[i].ed, 1'b0});
    end

    // Synchronizer latency: read one cycle after the pin edge sees the old level.
    cyc(0, 0, 7'h36, 8'h00, 8'h3C);
    cyc(1, 0, 7'h36, 8'h00, 8'h3C);
    check("pin_n+1_old", {23'd0, valid, rdata}, {23'd0, 1'b1, 8'h00});
    cyc(1, 0, 7'h36, 8'h00, 8'h3C);
    check("pin_n+2_new", {23'd0, valid, rdata}, {23'd0, 1'b1, 8'h3C});

`ifdef RISC8_GPIO_PCINT_EN
    cyc(0, 1, 7'h39, 8'h01, 8'h3C);
    cyc(0, 0, 7'h36, 8'h00, 8'h3D);
    cyc(0, 0, 7'h36, 8'h00, 8'h3D);
    check("irq_not_yet", {25'd0, irq}, 26'd0);
    cyc(0, 0, 7'h36, 8'h00, 8'h3D);
    check("irq_set", {25'd0, irq}, 26'd1);
    cyc(0, 1, 7'h3A, 8'h01, 8'h3D);
    check("irq_clear", {25'd0, irq}, 26'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 7'h36, 8'h00, 8'h3F);
    check("irq_masked", {25'd0, irq}, 26'd0);
`else
    cyc(1, 0, 7'h3A, 8'h00, 8'h3C);
    check("pcif_undecoded", {25'd0, valid | irq}, 26'd0);
`endif

    // Reset mid-transaction: pending response cleared at once, write lost.
    cyc(1, 0, 7'h38, 8'h00, 8'h3C);
    ren = 1; wen = 1; addr = 7'h37; wdata = 8'hFF;
    #2 reset = 1'b0;
    #1 check("async_reset", {valid, rdata, port, ddr, irq}, 26'd0);
    @(posedge clk); #1;
    reset = 1'b1; ren = 0; wen = 0;
    model_reset();
    cyc(1, 0, 7'h37, 8'h00, 8'h00);
    check("write_lost", {valid, rdata, port, ddr, irq}, {1'b1, 8'h00, 8'h00, 8'h00, 1'b0});

    for (int i = 0; i < 400; i++) begin
      logic [7:0] p;
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pin;
      cyc(1'($urandom), 1'($urandom), addr_pool[$urandom_range(0, 8)], 8'($urandom), p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
